line_fill_responder: RTL and testbench
======================================

# line_fill_responder

Memory-side responder for the cache's line-fill interface. It sits between the cache and the backing-store read port. When the cache raises `miss`, it fetches the 32 words of the missing line one at a time from the backing store. It then presents each word to the cache as a single-cycle `mem_data_valid` beat, with `mem_addr` incrementing by 4, and flags the final word with `mem_last`.

## Interface
- `LINE_WORDS`, 32: words per cache line (128 B line, 32-bit words).
- `ADDR_W`, 32: address width.
- `clk`  in  1  clock.
- `reset_n`  in  1  reset, synchronous, active-low.
- `cpu_addr`  in  32  CPU request address (word-aligned).
- `cpu_re`  in  1  CPU read strobe (single-cycle).
- `cpu_we`  in  1  CPU write strobe (single-cycle).
- `miss`  in  1  cache is in REPLACE and needs a line fill.
- `mem_addr`  out  32  fill word address; equals `cpu_addr` when not filling.
- `mem_data_in`  out  32  fill word to the cache.
- `mem_wstb`  out  4  constant `4'b1111`.
- `mem_data_valid`  out  1  one-cycle beat strobe.
- `mem_last`  out  1  high with beat 31 only.
- `rd_req`  out  1  backing-store read request.
- `rd_addr`  out  32  backing-store read address.
- `rd_ready`  in  1  backing store accepts the request (`rd_req & rd_ready` = accept).
- `rd_valid`  in  1  read data returned, one cycle.
- `rd_data`  in  32  read data.

## Operation
- States: IDLE, FETCH, WAIT, PRESENT, DONE.
- **IDLE:**
  - If `cpu_re|cpu_we`, latch `req_addr <= cpu_addr`.
  - If `miss`: set `base <= {req_addr[31:7], 7'b0}`, `beat <= 0`, go to FETCH.
  - `rd_valid` is ignored.
- **FETCH:**
  - `rd_req=1`, `rd_addr = base + 4*beat`.
  - Hold until `rd_ready`, then go to WAIT.
- **WAIT:** on `rd_valid`, capture `rd_data` into `mem_data_in`, go to PRESENT.
- **PRESENT:**
  - `mem_data_valid=1`; `mem_last = (beat==LINE_WORDS-1)`.
  - If last, go to DONE; otherwise `beat <= beat+1` and go to FETCH.
- **DONE:** go to IDLE when `miss==0`.
- `mem_addr`:
  - `base + 4*beat` in FETCH, WAIT and PRESENT; otherwise `cpu_addr`.
  - It therefore changes only in the cycle after a valid beat.
- `beat` is 5 bits and never wraps within a fill; exactly 32 beats occur per fill.
- `miss` is sampled only in IDLE and DONE. If `miss` deasserts mid-fill, the fill still completes.
- One outstanding read at most. A `rd_valid` outside WAIT is dropped.
- `mem_data_in` holds its last value between beats.

## Timing
- Reset (`reset_n=0` at a `clk` edge):
  - state IDLE, `beat=0`, `base=0`, `req_addr=0`, `mem_data_in=0`.
  - `mem_data_valid=0`, `mem_last=0`, `rd_req=0`, `rd_addr=0`; `mem_addr` mirrors `cpu_addr`.
- Reset mid-fill aborts immediately. No further beats are issued, and a late `rd_valid` is discarded in IDLE.
- Zero-wait backing store (`rd_ready=1`, `rd_valid` one cycle after accept), with `miss` first seen in IDLE at cycle N:
  - FETCH at N+1, WAIT at N+2, beat 0 at N+3.
  - Beat k at N+3+3k; `mem_last` at N+96; DONE at N+97.
- `mem_data_valid` is never high on two consecutive cycles; at least two low cycles separate beats.
- `mem_last` implies `mem_data_valid`.

## Structure
- Shared package: state enum `fill_state_t` (IDLE/FETCH/WAIT/PRESENT/DONE), `LINE_BYTES=128`, `WORD_BYTES=4`, `LINE_OFF_W=7`.
- Single module; no sub-module. The state register, beat counter and address/data registers all live in one always block, with combinational output decode.

## Test plan
- **Basic fill:**
  - Stimulus: `cpu_re` with `cpu_addr=0x0001_2344`, then `miss=1`, zero-wait store.
  - Response: 32 beats with `mem_addr` 0x0001_2300, 0x0001_2304 … 0x0001_237C.
  - Response: `mem_last` only at 0x0001_237C; beat 0 at N+3, last at N+96.
- **Back-pressure:**
  - Stimulus: `rd_ready` low for 5 cycles on beat 7, and `rd_valid` delayed 4 cycles.
  - Response: `rd_req` and `rd_addr` (0x…1C) held stable; no extra beat; beat count stays 32.
- **Data integrity:**
  - Stimulus: `rd_data` alternates 0xAAAAAAAA, 0x55555555.
  - Response: `mem_data_in` matches on each beat and holds between beats.
- **Reset mid-fill:**
  - Stimulus: `reset_n=0` during WAIT of beat 12, with a late `rd_valid` after reset.
  - Response: IDLE, all outputs at reset values, no `mem_data_valid`.
- **Miss held after last:**
  - Stimulus: `miss` kept high for 3 cycles after `mem_last`.
  - Response: stays in DONE with no new FETCH; returns to IDLE when `miss` falls.
- **Idle pass-through:**
  - Stimulus: random `cpu_addr` with `miss=0`.
  - Response: `mem_addr==cpu_addr` every cycle; `rd_req`, `mem_data_valid` and `mem_last` stay 0; `mem_wstb==4'b1111`.

Source files
------------

// File: rtl/line_fill_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : line_fill_responder_pkg
// Description : Shared types and line geometry for the cache line-fill
//               responder. The fill state enum and the byte/word offsets of
//               a 128-byte line of 32-bit words.
// Revision    : 1.0 - initial release
// ============================================================================
package line_fill_responder_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        WAIT    = 3'd2,
        PRESENT = 3'd3,
        DONE    = 3'd4
    } fill_state_t;

    localparam int LINE_BYTES = 128;
    localparam int WORD_BYTES = 4;
    localparam int LINE_OFF_W = 7;
    localparam int WORD_OFF_W = 2;
    // Width of the word index inside a line (32 words -> 5 bits).
    localparam int BEAT_W     = LINE_OFF_W - WORD_OFF_W;

endpackage : line_fill_responder_pkg
`default_nettype wire

// File: rtl/line_fill_responder.sv
`default_nettype none
// ============================================================================
// Module      : line_fill_responder
// Description : Memory-side responder for the cache line-fill interface.
//               On a miss it reads the 32 words of the missing line one at a
//               time from the backing store and presents each word to the
//               cache as a single-cycle beat, flagging the last one.
// Ports       : clk, reset_n      - clock, synchronous active-low reset
//               cpu_addr/re/we    - CPU request (address latched on re|we)
//               miss              - cache requests a line fill
//               mem_addr          - fill word address, else cpu_addr
//               mem_data_in       - fill word to the cache (held between beats)
//               mem_wstb          - constant full-word strobe
//               mem_data_valid    - one-cycle beat strobe
//               mem_last          - marks the final beat of a line
//               rd_req/rd_addr    - backing-store read request
//               rd_ready          - backing store accepts the request
//               rd_valid/rd_data  - backing-store read return
// Revision    : 1.0 - initial release
// ============================================================================
module line_fill_responder
    import line_fill_responder_pkg::*;
#(
    parameter int LINE_WORDS = 32,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_re,
    input  logic              cpu_we,
    input  logic              miss,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_data_in,
    output logic [3:0]        mem_wstb,
    output logic              mem_data_valid,
    output logic              mem_last,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_ready,
    input  logic              rd_valid,
    input  logic [31:0]       rd_data
);

    // Only the line-number bits of the request/base addresses are stored;
    // the offset bits of the base are always zero and the fill address is
    // rebuilt from {line, beat, word offset}.
    localparam int                c_line_w    = ADDR_W - LINE_OFF_W;
    localparam logic [BEAT_W-1:0] c_last_beat = BEAT_W'(LINE_WORDS - 1);

    fill_state_t         r_state;
    fill_state_t         w_next_state;
    logic [BEAT_W-1:0]   r_beat;
    logic [c_line_w-1:0] r_base_line;
    logic [c_line_w-1:0] r_req_line;
    logic [31:0]         r_data;

    logic [ADDR_W-1:0]   w_fill_addr;
    logic                w_last;

    assign w_fill_addr = {r_base_line, r_beat, {WORD_OFF_W{1'b0}}};
    assign w_last      = (r_beat == c_last_beat);
    assign mem_wstb    = 4'b1111;
    assign mem_data_in = r_data;

    // ------------------------------------------------------------------
    // State, beat counter and address/data registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_beat      <= '0;
            r_base_line <= '0;
            r_req_line  <= '0;
            r_data      <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                IDLE: begin
                    if (cpu_re || cpu_we) begin
                        r_req_line <= cpu_addr[ADDR_W-1:LINE_OFF_W];
                    end
                    // The base comes from the address latched on an earlier
                    // request, not from a strobe in this same cycle.
                    if (miss) begin
                        r_base_line <= r_req_line;
                        r_beat      <= '0;
                    end
                end
                WAIT: begin
                    if (rd_valid) begin
                        r_data <= rd_data;
                    end
                end
                PRESENT: begin
                    // The counter stops on the last word, so it never wraps
                    // within a fill.
                    if (!w_last) begin
                        r_beat <= r_beat + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output decode.
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state   = r_state;
        mem_addr       = cpu_addr;
        mem_data_valid = 1'b0;
        mem_last       = 1'b0;
        rd_req         = 1'b0;
        rd_addr        = '0;

        case (r_state)
            IDLE: begin
                if (miss) begin
                    w_next_state = FETCH;
                end
            end
            FETCH: begin
                mem_addr = w_fill_addr;
                rd_req   = 1'b1;
                rd_addr  = w_fill_addr;
                if (rd_ready) begin
                    w_next_state = WAIT;
                end
            end
            WAIT: begin
                mem_addr = w_fill_addr;
                if (rd_valid) begin
                    w_next_state = PRESENT;
                end
            end
            PRESENT: begin
                mem_addr       = w_fill_addr;
                mem_data_valid = 1'b1;
                mem_last       = w_last;
                w_next_state   = w_last ? DONE : FETCH;
            end
            DONE: begin
                // Wait for the cache to drop miss so one miss never
                // triggers a second fill.
                if (!miss) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

endmodule : line_fill_responder
`default_nettype wire

// File: tb/tb_line_fill_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_line_fill_responder
// Description : Self-checking bench for line_fill_responder. A backing-store
//               model answers read requests and pushes the expected beat
//               (address, data, last flag) into a scoreboard queue; a
//               monitor pops and compares on every mem_data_valid beat.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_line_fill_responder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] cpu_addr;
    logic        cpu_re;
    logic        cpu_we;
    logic        miss;
    logic [31:0] mem_addr;
    logic [31:0] mem_data_in;
    logic [3:0]  mem_wstb;
    logic        mem_data_valid;
    logic        mem_last;
    logic        rd_req;
    logic [31:0] rd_addr;
    logic        rd_ready;
    logic        rd_valid;
    logic [31:0] rd_data;

    always #5 clk = ~clk;

    line_fill_responder #(
        .LINE_WORDS (32),
        .ADDR_W     (32)
    ) u_dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cpu_addr       (cpu_addr),
        .cpu_re         (cpu_re),
        .cpu_we         (cpu_we),
        .miss           (miss),
        .mem_addr       (mem_addr),
        .mem_data_in    (mem_data_in),
        .mem_wstb       (mem_wstb),
        .mem_data_valid (mem_data_valid),
        .mem_last       (mem_last),
        .rd_req         (rd_req),
        .rd_addr        (rd_addr),
        .rd_ready       (rd_ready),
        .rd_valid       (rd_valid),
        .rd_data        (rd_data)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        last;
    } beat_t;

    beat_t sb_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Store configuration, written by the main sequence only.
    logic [31:0] exp_base    = '0;
    int          stall_beat  = -1;
    int          stall_n     = 0;
    int          delay_beat  = -1;
    int          delay_n     = 0;
    int          pattern     = 0;
    bit          store_en    = 1'b0;
    int          inject_req  = 0;

    // Store-private state.
    bit          st_ready_q  = 1'b0;
    bit          st_stalling = 1'b0;
    int          st_acc      = 0;
    int          st_pend     = -1;
    int          st_stall    = 0;
    int          inject_done = 0;
    logic [31:0] st_pdata    = '0;

    // Monitor-private state.
    int          beats       = 0;
    int          beat_cyc[256];
    bit          hold_chk    = 1'b0;
    bit          prev1       = 1'b0;
    bit          prev2       = 1'b0;
    logic [31:0] last_data   = '0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pattern_word(input int idx);
        if (pattern == 1) begin
            return idx[0] ? 32'h5555_5555 : 32'hAAAA_AAAA;
        end
        return 32'hC0DE_0000 ^ (32'(idx) * 32'h0101_0101) ^ exp_base;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // ------------------------------------------------------------------
    // Backing-store model: grants rd_ready while rd_req is seen (with an
    // optional stall), returns data after an optional delay, and pushes the
    // expected beat when it drives rd_valid.
    // ------------------------------------------------------------------
    initial begin
        rd_ready = 1'b0;
        rd_valid = 1'b0;
        rd_data  = '0;
        forever begin
            beat_t e;
            @(posedge clk);
            #1;
            rd_valid = 1'b0;
            rd_ready = 1'b0;
            if (inject_req != inject_done) begin
                inject_done = inject_req;
                rd_valid    = 1'b1;
                rd_data     = 32'h1234_5678;
            end else if (!store_en) begin
                st_ready_q  = 1'b0;
                st_stalling = 1'b0;
                st_acc      = 0;
                st_pend     = -1;
                st_stall    = 0;
            end else begin
                if (st_ready_q) begin
                    st_ready_q = 1'b0;
                    st_pdata   = pattern_word(st_acc);
                    st_pend    = (st_acc == delay_beat) ? delay_n : 0;
                    st_acc++;
                end
                if (st_pend == 0) begin
                    rd_valid = 1'b1;
                    rd_data  = st_pdata;
                    e.addr   = exp_base + 32'(4 * (st_acc - 1));
                    e.data   = st_pdata;
                    e.last   = (st_acc == 32);
                    sb_q.push_back(e);
                    st_pend  = -1;
                end else if (st_pend > 0) begin
                    st_pend--;
                end else begin
                    if (st_stalling) begin
                        check("rd_req_hold", 32'(rd_req), 32'd1);
                    end
                    if (rd_req) begin
                        check("rd_addr", rd_addr, exp_base + 32'(4 * st_acc));
                        if (st_acc == stall_beat && st_stall < stall_n) begin
                            st_stall++;
                            st_stalling = 1'b1;
                        end else begin
                            st_stalling = 1'b0;
                            rd_ready    = 1'b1;
                            st_ready_q  = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Beat monitor.
    // ------------------------------------------------------------------
    initial forever begin
        beat_t e;
        @(negedge clk);
        if (!reset_n) begin
            hold_chk = 1'b0;
            prev1    = 1'b0;
            prev2    = 1'b0;
        end else begin
            if (mem_last) begin
                check("last_implies_valid", 32'(mem_data_valid), 32'd1);
            end
            if (mem_data_valid) begin
                check("beat_gap", {30'd0, prev1, prev2}, 32'd0);
                check("beat_expected", 32'(sb_q.size() > 0), 32'd1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    check("beat_addr", mem_addr, e.addr);
                    check("beat_data", mem_data_in, e.data);
                    check("beat_last", 32'(mem_last), 32'(e.last));
                end
                if (beats < 256) begin
                    beat_cyc[beats] = cyc;
                end
                beats++;
                last_data = mem_data_in;
                hold_chk  = 1'b1;
            end else if (hold_chk) begin
                check("data_hold", mem_data_in, last_data);
            end
            prev2 = prev1;
            prev1 = mem_data_valid;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_req"},   32'(rd_req),         32'd0);
        check({tag, "_rd_addr"},  rd_addr,             32'd0);
        check({tag, "_valid"},    32'(mem_data_valid), 32'd0);
        check({tag, "_last"},     32'(mem_last),       32'd0);
        check({tag, "_data"},     mem_data_in,         32'd0);
        check({tag, "_mem_addr"}, mem_addr,            cpu_addr);
        check({tag, "_wstb"},     32'(mem_wstb),       32'hF);
    endtask

    task automatic run_fill(input logic [31:0] a, input bit use_we,
                            input int sb, input int sn, input int db, input int dn,
                            input int pat, input int hold, input bit timing);
        int n;
        int b0;
        int t;
        cpu_addr = a;
        cpu_re   = !use_we;
        cpu_we   = use_we;
        step();
        cpu_re     = 1'b0;
        cpu_we     = 1'b0;
        exp_base   = {a[31:7], 7'b0};
        stall_beat = sb;
        stall_n    = sn;
        delay_beat = db;
        delay_n    = dn;
        pattern    = pat;
        store_en   = 1'b1;
        b0         = beats;
        miss       = 1'b1;
        n          = cyc;
        step();
        t = 0;
        while ((beats - b0) < 32 && t < 600) begin
            step();
            t++;
        end
        // Now in DONE; keep miss high and make sure no new fetch starts.
        for (int i = 0; i < hold; i++) begin
            step();
            check("done_no_fetch", 32'(rd_req), 32'd0);
        end
        miss = 1'b0;
        step();
        store_en = 1'b0;
        repeat (4) step();
        check("beat_count", 32'(beats - b0), 32'd32);
        check("idle_no_rd_req", 32'(rd_req), 32'd0);
        check("idle_mem_addr", mem_addr, cpu_addr);
        if (timing && (beats - b0) >= 32) begin
            check("beat0_cycle", 32'(beat_cyc[b0]), 32'(n + 3));
            check("last_cycle",  32'(beat_cyc[b0 + 31]), 32'(n + 96));
        end
    endtask

    initial begin
        int b0;
        int t;
        reset_n  = 1'b0;
        cpu_addr = 32'h0000_1234;
        cpu_re   = 1'b0;
        cpu_we   = 1'b0;
        miss     = 1'b0;
        repeat (3) step();
        check_reset_outputs("reset");
        reset_n = 1'b1;
        step();

        // Idle pass-through.
        for (int i = 0; i < 16; i++) begin
            cpu_addr = $urandom() & 32'hFFFF_FFFC;
            cpu_re   = ($urandom_range(0, 3) == 0);
            #2;
            check("pt_mem_addr", mem_addr, cpu_addr);
            check("pt_rd_req",   32'(rd_req), 32'd0);
            check("pt_valid",    32'(mem_data_valid), 32'd0);
            check("pt_last",     32'(mem_last), 32'd0);
            check("pt_wstb",     32'(mem_wstb), 32'hF);
            step();
        end
        cpu_re = 1'b0;

        // Basic fill with zero-wait store and cycle timing.
        run_fill(32'h0001_2344, 1'b0, -1, 0, -1, 0, 0, 0, 1'b1);
        // Back-pressure on beat 7: ready stall and delayed read data.
        run_fill(32'h0040_0064, 1'b0, 7, 5, 7, 4, 0, 0, 1'b0);
        // Alternating data at the top of the address space, latched by a write.
        run_fill(32'hFFFF_FFFC, 1'b1, -1, 0, -1, 0, 1, 0, 1'b1);
        // Miss held for three cycles after the last beat.
        run_fill(32'h0000_5A80, 1'b0, -1, 0, -1, 0, 0, 3, 1'b1);

        // Reset during WAIT of beat 12, followed by a late rd_valid.
        cpu_addr = 32'h0000_A004;
        cpu_re   = 1'b1;
        step();
        cpu_re     = 1'b0;
        exp_base   = 32'h0000_A000;
        stall_beat = -1;
        delay_beat = 12;
        delay_n    = 20;
        pattern    = 0;
        store_en   = 1'b1;
        b0         = beats;
        miss       = 1'b1;
        step();
        t = 0;
        while ((beats - b0) < 12 && t < 200) begin
            step();
            t++;
        end
        check("pre_reset_beats", 32'(beats - b0), 32'd12);
        step();
        reset_n  = 1'b0;
        store_en = 1'b0;
        miss     = 1'b0;
        step();
        check_reset_outputs("midreset");
        reset_n = 1'b1;
        inject_req++;
        repeat (5) step();
        check("post_reset_beats", 32'(beats - b0), 32'd12);
        check("post_reset_sb_empty", 32'(sb_q.size()), 32'd0);
        check_reset_outputs("late_valid");

        // Recovery: a normal fill after the abort.
        run_fill(32'h0003_0000, 1'b0, -1, 0, -1, 0, 0, 0, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected completion within 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_line_fill_responder
`default_nettype wire
